// File: rtl/ctrl_pipe_chain.sv
// Control-word pipeline: packs raw decoder control bits and carries them through STAGES
// registers with hold, flush/stall bubble insertion and a saturating bubble counter.
module ctrl_pipe_chain #(
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned OUT_W  = 32,
  parameter int unsigned STAGES = 3,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [CTRL_W-1:0]         ctrl_i,
  input  logic                      valid_i,
  input  logic                      stall_i,
  input  logic                      flush_i,
  input  logic                      hold_i,
  output logic [STAGES*OUT_W-1:0]   ctrl_o,
  output logic [STAGES-1:0]         valid_o,
  output logic [CNT_W-1:0]          bubble_cnt_o
);

  // Only the raw control bits are stored; the zero padding is constant wiring.
  logic [STAGES*CTRL_W-1:0] word_q, word_d, word_in;
  logic [STAGES-1:0]        valid_q, valid_d, valid_in;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     load;

  always_comb begin
    load     = valid_i && !stall_i && !flush_i;
    word_in  = '0;
    valid_in = '0;
    word_in[CTRL_W-1:0] = load ? ctrl_i : '0;
    valid_in[0]         = load;

    word_d  = word_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (!hold_i) begin
      // Shift toward the last stage; stage 0 takes the new word or a bubble.
      word_d  = (word_q << CTRL_W) | word_in;
      valid_d = (valid_q << 1) | valid_in;
      if (!load && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      word_q  <= '0;
      valid_q <= '0;
      cnt_q   <= '0;
    end else begin
      word_q  <= word_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    ctrl_o = '0;
    for (int k = 0; k < STAGES; k++) begin
      ctrl_o[k*OUT_W +: CTRL_W] = word_q[k*CTRL_W +: CTRL_W];
    end
  end

  assign valid_o      = valid_q;
  assign bubble_cnt_o = cnt_q;

endmodule

// File: tb/tb_ctrl_pipe_chain.sv
// Bench for ctrl_pipe_chain: directed scenarios with literal expectations, then random traffic
// checked every cycle against a history-queue model (default instance plus a 1-stage CNT_W=4 one).
module tb_ctrl_pipe_chain;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  ctrl = '0;
  logic        valid = 1'b0, stall = 1'b0, flush = 1'b0, hold = 1'b0;

  logic [95:0] ctrl_o;
  logic [2:0]  valid_o;
  logic [15:0] cnt_o;
  logic [7:0]  s_ctrl_o;
  logic        s_valid_o;
  logic [3:0]  s_cnt_o;

  int checks = 0;
  int failures = 0;

  // Model: newest entry at index 0; stage k shows the entry pushed k unheld edges ago.
  logic [8:0]  hist[$];
  longint      nbub = 0;

  always #5 clk = ~clk;

  ctrl_pipe_chain dut (
    .clk_i(clk), .rst_i(rst_n), .ctrl_i(ctrl), .valid_i(valid), .stall_i(stall),
    .flush_i(flush), .hold_i(hold), .ctrl_o(ctrl_o), .valid_o(valid_o), .bubble_cnt_o(cnt_o)
  );

  ctrl_pipe_chain #(.CTRL_W(8), .OUT_W(8), .STAGES(1), .CNT_W(4)) dut_s (
    .clk_i(clk), .rst_i(rst_n), .ctrl_i(ctrl), .valid_i(valid), .stall_i(stall),
    .flush_i(flush), .hold_i(hold), .ctrl_o(s_ctrl_o), .valid_o(s_valid_o),
    .bubble_cnt_o(s_cnt_o)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [8:0] m_stage(input int k);
    if (k < hist.size()) return hist[k];
    return 9'h0;
  endfunction

  // One clock edge: model advances on the same edge using the inputs seen before it.
  task automatic tick();
    logic [8:0] e;
    bit         adv;
    adv = rst_n && !hold;
    e = (valid && !stall && !flush) ? {1'b1, ctrl} : 9'h0;
    @(posedge clk);
    if (adv) begin
      hist.push_front(e);
      if (hist.size() > 3) void'(hist.pop_back());
      if (e[8] == 1'b0) nbub++;
    end
    #1;
  endtask

  task automatic drive(input bit v, input logic [7:0] c, input bit st, input bit fl, input bit h);
    valid = v; ctrl = c; stall = st; flush = fl; hold = h;
  endtask

  always @(negedge clk) begin : compare
    logic [95:0] exp_ctrl;
    logic [2:0]  exp_valid;
    logic [8:0]  e;
    exp_ctrl = '0;
    for (int k = 0; k < 3; k++) begin
      e = m_stage(k);
      exp_ctrl[k*32 +: 32] = {24'h0, e[7:0]};
      exp_valid[k] = e[8];
    end
    e = m_stage(0);
    chk("model_ctrl", 128'(ctrl_o), 128'(exp_ctrl));
    chk("model_valid", 128'(valid_o), 128'(exp_valid));
    chk("model_cnt", 128'(cnt_o), 128'((nbub > 65535) ? 65535 : nbub));
    chk("model_s_ctrl", 128'(s_ctrl_o), 128'(e[7:0]));
    chk("model_s_valid", 128'(s_valid_o), 128'(e[8]));
    chk("model_s_cnt", 128'(s_cnt_o), 128'((nbub > 15) ? 15 : nbub));
  end

  initial begin
    #2;
    chk("reset_ctrl", 128'(ctrl_o), 128'(0));
    chk("reset_valid", 128'(valid_o), 128'(0));
    chk("reset_cnt", 128'(cnt_o), 128'(0));
    tick(); tick();
    rst_n = 1'b1;

    // Single A5 walks down the chain.
    drive(1, 8'hA5, 0, 0, 0); tick();
    drive(0, 8'h00, 0, 0, 0);
    chk("a5_s0", 128'(ctrl_o), 128'({32'h0, 32'h0, 32'h000000A5}));
    chk("a5_v0", 128'(valid_o), 128'(3'b001));
    chk("a5_c0", 128'(cnt_o), 128'(0));
    tick();
    chk("a5_s1", 128'(ctrl_o), 128'({32'h0, 32'h000000A5, 32'h0}));
    chk("a5_v1", 128'(valid_o), 128'(3'b010));
    chk("a5_c1", 128'(cnt_o), 128'(1));
    tick();
    chk("a5_s2", 128'(ctrl_o), 128'({32'h000000A5, 32'h0, 32'h0}));
    chk("a5_v2", 128'(valid_o), 128'(3'b100));
    chk("a5_c2", 128'(cnt_o), 128'(2));

    // Stall on the second of three.
    drive(1, 8'h11, 0, 0, 0); tick();
    drive(1, 8'h22, 1, 0, 0); tick();
    chk("stall_bubble", 128'({ctrl_o[31:0], valid_o[0]}), 128'({32'h0, 1'b0}));
    chk("stall_cnt", 128'(cnt_o), 128'(3));
    drive(1, 8'h33, 0, 0, 0); tick();
    chk("stall_after", 128'(ctrl_o), 128'({32'h11, 32'h0, 32'h33}));
    chk("stall_valid", 128'(valid_o), 128'(3'b101));

    // Three valid in flight, then hold for 3 cycles with a flush pulsed inside it.
    drive(1, 8'h44, 0, 0, 0); tick();
    drive(1, 8'h55, 0, 0, 0); tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 8'h99, i == 1, i == 1, 1); tick();
      chk("hold_ctrl", 128'(ctrl_o), 128'({32'h33, 32'h44, 32'h55}));
      chk("hold_valid", 128'(valid_o), 128'(3'b111));
      chk("hold_cnt", 128'(cnt_o), 128'(3));
    end
    drive(1, 8'h66, 0, 0, 0); tick();
    chk("resume_ctrl", 128'(ctrl_o), 128'({32'h44, 32'h55, 32'h66}));

    // Flush and stall together: one bubble, one count.
    drive(1, 8'h77, 1, 1, 0); tick();
    chk("fs_ctrl", 128'(ctrl_o), 128'({32'h55, 32'h66, 32'h0}));
    chk("fs_valid", 128'(valid_o), 128'(3'b110));
    chk("fs_cnt", 128'(cnt_o), 128'(4));

    // 20 bubbles: 4-bit counter pins at F.
    for (int i = 0; i < 20; i++) begin
      drive(0, 8'($urandom), 0, 0, 0); tick();
    end
    chk("sat_small", 128'(s_cnt_o), 128'(4'hF));
    chk("sat_main", 128'(cnt_o), 128'(24));

    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 7) == 0,
            $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0);
      tick();
    end

    // Asynchronous reset between edges.
    drive(1, 8'hC3, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    hist.delete();
    nbub = 0;
    #1;
    chk("async_ctrl", 128'(ctrl_o), 128'(0));
    chk("async_valid", 128'(valid_o), 128'(0));
    chk("async_cnt", 128'(cnt_o), 128'(0));
    chk("async_s", 128'({s_ctrl_o, s_valid_o, s_cnt_o}), 128'(0));
    tick();
    rst_n = 1'b1;
    drive(1, 8'h5A, 0, 0, 0); tick();
    chk("post_rst_s0", 128'(ctrl_o), 128'({32'h0, 32'h0, 32'h5A}));
    chk("post_rst_v", 128'(valid_o), 128'(3'b001));

    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 7) == 0,
            $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0);
      tick();
    end

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
